// File: rtl/seg7_pkg.sv
// Seven-segment glyph table shared by display-side blocks.
// Glyphs are logical {a,b,c,d,e,f,g}, segment on = 1.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            // Only reachable with X/Z in simulation: show a blank digit.
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_7seg_decoder.sv
// Registered hex-to-seven-segment decoder for one display digit.
// Polarity is folded in before the register so every pin is a flop output.
module hex_7seg_decoder
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] in,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d,
    output logic       o_e,
    output logic       o_f,
    output logic       o_g
);

    localparam logic [6:0] POL = {7{ACTIVE_LOW}};

    logic [6:0] seg_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) seg_q <= SEG_BLANK ^ POL;
        else       seg_q <= hex_to_seg(in) ^ POL;
    end

    assign {o_a, o_b, o_c, o_d, o_e, o_f, o_g} = seg_q;

endmodule

// File: tb/tb_hex_7seg_decoder.sv
// Self-checking bench: active-high and active-low decoders driven side by side.
module tb_hex_7seg_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in;
    logic       ha, hb, hc, hd, he, hf, hg;
    logic       la, lb, lc, ld, le, lf, lg;
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    hex_7seg_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
        .i_clk(clk), .i_rst(rst), .in(in),
        .o_a(ha), .o_b(hb), .o_c(hc), .o_d(hd), .o_e(he), .o_f(hf), .o_g(hg)
    );

    hex_7seg_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
        .i_clk(clk), .i_rst(rst), .in(in),
        .o_a(la), .o_b(lb), .o_c(lc), .o_d(ld), .o_e(le), .o_f(lf), .o_g(lg)
    );

    wire [6:0] seg_hi = {ha, hb, hc, hd, he, hf, hg};
    wire [6:0] seg_lo = {la, lb, lc, ld, le, lf, lg};

    // Reference glyphs, transcribed from the display table ({a..g}, on = 1).
    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] glyph(input logic [3:0] v);
        return glyph_tab[v];
    endfunction

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in  = 4'h8;
        step();
        step();
        vectors++;
        if (seg_hi !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_hi got=%b exp=%b", seg_hi, 7'b0000000);
        end
        vectors++;
        if (seg_lo !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_lo got=%b exp=%b", seg_lo, 7'b1111111);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            in = 4'(v);
            step();
            vectors++;
            if (seg_hi !== glyph(4'(v))) begin
                errors++;
                $display("FAIL sweep_hi in=%h got=%b exp=%b", v, seg_hi, glyph(4'(v)));
            end
            vectors++;
            if (seg_lo !== ~glyph(4'(v))) begin
                errors++;
                $display("FAIL sweep_lo in=%h got=%b exp=%b", v, seg_lo, ~glyph(4'(v)));
            end
        end
    endtask

    task automatic test_latency();
        in = 4'h1;
        step();
        vectors++;
        if (seg_hi !== 7'b0110000) begin
            errors++;
            $display("FAIL latency_load got=%b exp=%b", seg_hi, 7'b0110000);
        end
        in = 4'h8;
        #1;
        vectors++;
        if (seg_hi !== 7'b0110000) begin
            errors++;
            $display("FAIL latency_comb got=%b exp=%b", seg_hi, 7'b0110000);
        end
        @(negedge clk);
        vectors++;
        if (seg_hi !== 7'b0110000) begin
            errors++;
            $display("FAIL latency_mid got=%b exp=%b", seg_hi, 7'b0110000);
        end
        step();
        vectors++;
        if (seg_hi !== 7'b1111111) begin
            errors++;
            $display("FAIL latency_edge got=%b exp=%b", seg_hi, 7'b1111111);
        end
    endtask

    task automatic test_midstream_reset();
        in = 4'h3;
        step();
        vectors++;
        if (seg_hi !== 7'b1111001) begin
            errors++;
            $display("FAIL midrst_pre got=%b exp=%b", seg_hi, 7'b1111001);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (seg_hi !== 7'b0000000) begin
            errors++;
            $display("FAIL midrst_blank got=%b exp=%b", seg_hi, 7'b0000000);
        end
        vectors++;
        if (seg_lo !== 7'b1111111) begin
            errors++;
            $display("FAIL midrst_blank_lo got=%b exp=%b", seg_lo, 7'b1111111);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (seg_hi !== 7'b1111001) begin
            errors++;
            $display("FAIL midrst_post got=%b exp=%b", seg_hi, 7'b1111001);
        end
    endtask

    task automatic test_inverted();
        in = 4'h2;
        step();
        vectors++;
        if (seg_lo !== 7'b0010010) begin
            errors++;
            $display("FAIL inv_2 got=%b exp=%b", seg_lo, 7'b0010010);
        end
        in = 4'hB;
        step();
        vectors++;
        if (seg_lo !== 7'b1100000) begin
            errors++;
            $display("FAIL inv_b got=%b exp=%b", seg_lo, 7'b1100000);
        end
    endtask

    // Random back-to-back values with occasional reset pulses.
    task automatic test_back_to_back();
        logic [6:0] exp_hi;
        for (int n = 0; n < 300; n++) begin
            in  = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 7) == 0);
            exp_hi = rst ? 7'b0000000 : glyph(in);
            step();
            vectors++;
            if (seg_hi !== exp_hi) begin
                errors++;
                $display("FAIL b2b_hi n=%0d in=%h rst=%b got=%b exp=%b", n, in, rst, seg_hi, exp_hi);
            end
            vectors++;
            if (seg_lo !== ~exp_hi) begin
                errors++;
                $display("FAIL b2b_lo n=%0d in=%h rst=%b got=%b exp=%b", n, in, rst, seg_lo, ~exp_hi);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in  = 4'h8;
        test_reset();
        test_sweep();
        test_latency();
        test_midstream_reset();
        test_inverted();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
